data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Sequences and shares the single-port data memory between two requesters:
//  the core load/store path (core_*) and an external/debug port (ext_*).
//  Accepts one transaction at a time via valid/ready, issues a one-cycle
//  mem_read/mem_write strobe, and returns a one-cycle response pulse.
//  Sits between the control unit's memory port and the data memory instance.
// PARAMETERS
//  ADDR_W      16  address width
//  DATA_W      64  data width
//  RD_LATENCY  1   cycles from mem_read strobe to valid mem_rdata (>=1)
// PORTS
//  clk             in   1       clock, rising edge
//  reset           in   1       asynchronous, active-low reset
//  core_req_valid  in   1       core request present
//  core_req_ready  out  1       core request accepted this cycle
//  core_req_we     in   1       1=write, 0=read
//  core_req_addr   in   ADDR_W  core address
//  core_req_wdata  in   DATA_W  core write data
//  core_rsp_valid  out  1       one-cycle completion pulse
//  core_rsp_rdata  out  DATA_W  read data, held until next core read response
//  ext_req_*/ext_rsp_*          same set as core_*, for the external port
//  mem_addr        out  ADDR_W  memory address
//  mem_wdata       out  DATA_W  memory write data
//  mem_write       out  1       write strobe
//  mem_read        out  1       read strobe
//  mem_rdata       in   DATA_W  memory read data
//  busy            out  1       state != IDLE
// BEHAVIOUR
//  - Reset (async, reset==0): state=IDLE, all outputs 0, counter 0, RR pointer=ext.
//    In-flight transaction dropped; no response is ever issued for it.
//  - FSM: IDLE -> ISSUE -> (read) WAIT -> RESP -> IDLE; (write) ISSUE -> RESP.
//  - IDLE: if any valid, winner's req_ready=1 (combinational, same cycle);
//    accept when valid&ready at cycle T; command latched; -> ISSUE. Loser ready=0.
//    Ready is 0 in all other states.
//  - ISSUE (T+1): mem_addr/mem_wdata driven from latch; mem_write=we, mem_read=~we,
//    exactly one strobe for one cycle. Write -> RESP. Read -> WAIT, counter loaded.
//  - WAIT: count RD_LATENCY cycles; mem_rdata sampled at T+1+RD_LATENCY; -> RESP.
//  - RESP: winner's rsp_valid=1 for one cycle; -> IDLE.
//    Write response at T+2; read response at T+2+RD_LATENCY.
//  - No response backpressure. Requester holds valid and fields stable until ready.
//  - rsp_rdata is updated only on that port's read response; write responses
//    leave it unchanged. mem_addr/mem_wdata hold their last values when idle.
//  - Next acceptance: earliest in the IDLE cycle after RESP (3 cycles per write).
//  - Counter width $clog2(RD_LATENCY+1). No wrap: loaded on each read issue.
//  - Valid dropped by a requester while not ready: ignored, with no side effect.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN undefined: fixed priority, core beats ext on a simultaneous
//    valid, and ext can starve.
//  ARB_ROUND_ROBIN_EN defined: 1-bit pointer holds the last grantee. On a
//    simultaneous valid the other port wins. The pointer updates only on
//    acceptance. Reset pointer=ext, so core wins the first tie.
//  A single valid always wins regardless of mode.
// TESTING
//  1 Hold reset=0 with both valid=1: all outputs 0, busy=0. Release: core accepted
//    in the first cycle.
//  2 Core write addr=0x0010, wdata=0xDEADBEEF accepted at T: mem_write=1,
//    mem_addr=0x0010 at T+1; core_rsp_valid=1 at T+2 only; ext_rsp_valid stays 0.
//  3 Core read 0x0020 (RD_LATENCY=1), memory returns 0x1234 at T+2:
//    core_rsp_valid=1 at T+3, core_rsp_rdata=0x1234 held after the pulse.
//  4 Both valid continuously with 4 reads each. No macro: core granted 4 times
//    before any ext grant. With macro: grant order core,ext,core,ext,...
//  5 Ext read with RD_LATENCY=3 accepted at T: mem_read at T+1 only;
//    ext_rsp_valid at T+5.
//  6 Reset asserted in WAIT: no rsp pulse, all outputs 0. After release,
//    a fresh core write completes normally at T+2.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one single-port data memory between the core
// load/store path (core_*) and an external/debug port (ext_*).
// One transaction in flight at a time: IDLE -> ISSUE -> [WAIT] -> RESP.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin arbitration on
// simultaneous requests; otherwise core has fixed priority over ext.
module data_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 64,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req_valid,
  output logic              core_req_ready,
  input  logic              core_req_we,
  input  logic [ADDR_W-1:0] core_req_addr,
  input  logic [DATA_W-1:0] core_req_wdata,
  output logic              core_rsp_valid,
  output logic [DATA_W-1:0] core_rsp_rdata,
  input  logic              ext_req_valid,
  output logic              ext_req_ready,
  input  logic              ext_req_we,
  input  logic [ADDR_W-1:0] ext_req_addr,
  input  logic [DATA_W-1:0] ext_req_wdata,
  output logic              ext_rsp_valid,
  output logic [DATA_W-1:0] ext_rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(RD_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  typedef enum logic {PORT_CORE = 1'b0, PORT_EXT = 1'b1} port_t;

  state_t            state_q, state_d;
  port_t             lat_port;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [CNT_W-1:0]  cnt_q;
  logic              grant_ext;
  logic              accept;
  logic              rd_done;

`ifdef ARB_ROUND_ROBIN_EN
  port_t rr_ptr;

  // Round-robin pointer: remembers the last grantee, moves only on acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      rr_ptr <= PORT_EXT;
    else if (accept) rr_ptr <= grant_ext ? PORT_EXT : PORT_CORE;
  end
`endif

  // Winner selection; a lone valid always wins, ties depend on the mode.
  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_ext = ext_req_valid;
    if (core_req_valid && ext_req_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_ext = (rr_ptr == PORT_CORE);
`else
      grant_ext = 1'b0;
`endif
    end
  end

  // Ready is gated by reset so the requesters see 0 while reset is held.
  assign accept         = (state_q == S_IDLE) && reset && (core_req_valid || ext_req_valid);
  assign core_req_ready = accept && !grant_ext;
  assign ext_req_ready  = accept && grant_ext;
  assign rd_done        = (state_q == S_WAIT) && (cnt_q == CNT_LAST);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: state_d = lat_we ? S_RESP : S_WAIT;
      S_WAIT:  if (cnt_q == CNT_LAST) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Command latch: captures the winner's request at acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_port  <= PORT_CORE;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_port  <= grant_ext ? PORT_EXT : PORT_CORE;
      lat_we    <= grant_ext ? ext_req_we    : core_req_we;
      lat_addr  <= grant_ext ? ext_req_addr  : core_req_addr;
      lat_wdata <= grant_ext ? ext_req_wdata : core_req_wdata;
    end
  end

  // Read latency counter: loaded on each read issue, counts down in WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                  cnt_q <= '0;
    else if (state_q == S_ISSUE && !lat_we)      cnt_q <= CNT_LOAD;
    else if (state_q == S_WAIT)                  cnt_q <= cnt_q - CNT_LAST;
  end

  // Per-port read data: updated only when that port's read completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_rsp_rdata <= '0;
      ext_rsp_rdata  <= '0;
    end else if (rd_done) begin
      if (lat_port == PORT_EXT) ext_rsp_rdata  <= mem_rdata;
      else                      core_rsp_rdata <= mem_rdata;
    end
  end

  // Memory command and response strobes decoded from state and latch.
  assign mem_addr       = lat_addr;
  assign mem_wdata      = lat_wdata;
  assign mem_write      = (state_q == S_ISSUE) && lat_we;
  assign mem_read       = (state_q == S_ISSUE) && !lat_we;
  assign core_rsp_valid = (state_q == S_RESP) && (lat_port == PORT_CORE);
  assign ext_rsp_valid  = (state_q == S_RESP) && (lat_port == PORT_EXT);
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Testbench for data_mem_arbiter: two instances (read latency 1 and 3) with
// a delayed-read memory model; a monitor logs DUT events and each test task
// compares them against an expected-event queue built while driving.
module tb_data_mem_arbiter;

  localparam logic [2:0] K_ACC_C = 3'd0, K_ACC_E = 3'd1, K_WR = 3'd2,
                         K_RD = 3'd3, K_RSP_C = 3'd4, K_RSP_E = 3'd5;
  localparam logic [63:0] JUNK = 64'hBADD_F00D_BADD_F00D;

  typedef struct packed {
    logic [2:0]  kind;
    int          cyc;
    logic [15:0] addr;
    logic [63:0] data;
  } ev_t;

  logic        clk;
  logic        reset;
  logic        core_req_valid[2], core_req_ready[2], core_req_we[2];
  logic [15:0] core_req_addr[2];
  logic [63:0] core_req_wdata[2];
  logic        core_rsp_valid[2];
  logic [63:0] core_rsp_rdata[2];
  logic        ext_req_valid[2], ext_req_ready[2], ext_req_we[2];
  logic [15:0] ext_req_addr[2];
  logic [63:0] ext_req_wdata[2];
  logic        ext_rsp_valid[2];
  logic [63:0] ext_rsp_rdata[2];
  logic [15:0] mem_addr[2];
  logic [63:0] mem_wdata[2];
  logic        mem_write[2], mem_read[2];
  logic [63:0] mem_rdata[2];
  logic        busy[2];

  int          cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  ev_t         obs_q[2][$];
  ev_t         exp_q[$];
  logic [63:0] held[2][2];
  logic [2:0]  rd_pipe[2];
  logic [15:0] a_pipe[2][3];

  data_mem_arbiter #(.ADDR_W(16), .DATA_W(64), .RD_LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(reset),
    .core_req_valid(core_req_valid[0]), .core_req_ready(core_req_ready[0]),
    .core_req_we(core_req_we[0]), .core_req_addr(core_req_addr[0]),
    .core_req_wdata(core_req_wdata[0]), .core_rsp_valid(core_rsp_valid[0]),
    .core_rsp_rdata(core_rsp_rdata[0]),
    .ext_req_valid(ext_req_valid[0]), .ext_req_ready(ext_req_ready[0]),
    .ext_req_we(ext_req_we[0]), .ext_req_addr(ext_req_addr[0]),
    .ext_req_wdata(ext_req_wdata[0]), .ext_rsp_valid(ext_rsp_valid[0]),
    .ext_rsp_rdata(ext_rsp_rdata[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_write(mem_write[0]),
    .mem_read(mem_read[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  data_mem_arbiter #(.ADDR_W(16), .DATA_W(64), .RD_LATENCY(3)) u_dut_l3 (
    .clk(clk), .reset(reset),
    .core_req_valid(core_req_valid[1]), .core_req_ready(core_req_ready[1]),
    .core_req_we(core_req_we[1]), .core_req_addr(core_req_addr[1]),
    .core_req_wdata(core_req_wdata[1]), .core_rsp_valid(core_rsp_valid[1]),
    .core_rsp_rdata(core_rsp_rdata[1]),
    .ext_req_valid(ext_req_valid[1]), .ext_req_ready(ext_req_ready[1]),
    .ext_req_we(ext_req_we[1]), .ext_req_addr(ext_req_addr[1]),
    .ext_req_wdata(ext_req_wdata[1]), .ext_rsp_valid(ext_rsp_valid[1]),
    .ext_rsp_rdata(ext_rsp_rdata[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_write(mem_write[1]),
    .mem_read(mem_read[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents as a pure function of address.
  function automatic logic [63:0] model_data(input logic [15:0] a);
    if (a == 16'h0020) return 64'h0000_0000_0000_1234;
    return {a, ~a, a ^ 16'h5A5A, ~a ^ 16'h0F0F};
  endfunction

  // Memory model: data valid exactly RD_LATENCY cycles after the read strobe.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pipe[0] <= '0;
      rd_pipe[1] <= '0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        rd_pipe[d]   <= {rd_pipe[d][1:0], mem_read[d]};
        a_pipe[d][0] <= mem_addr[d];
        a_pipe[d][1] <= a_pipe[d][0];
        a_pipe[d][2] <= a_pipe[d][1];
      end
    end
  end
  assign mem_rdata[0] = rd_pipe[0][0] ? model_data(a_pipe[0][0]) : JUNK;
  assign mem_rdata[1] = rd_pipe[1][2] ? model_data(a_pipe[1][2]) : JUNK;

  function automatic ev_t mk(input logic [2:0] k, input int c, input logic [15:0] a,
                             input logic [63:0] dat);
    ev_t e;
    e.kind = k; e.cyc = c; e.addr = a; e.data = dat;
    return e;
  endfunction

  // Event monitor, sampled on the falling edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (core_req_valid[d] && core_req_ready[d]) obs_q[d].push_back(mk(K_ACC_C, cyc, 16'h0, 64'h0));
      if (ext_req_valid[d] && ext_req_ready[d])   obs_q[d].push_back(mk(K_ACC_E, cyc, 16'h0, 64'h0));
      if (mem_write[d])      obs_q[d].push_back(mk(K_WR, cyc, mem_addr[d], mem_wdata[d]));
      if (mem_read[d])       obs_q[d].push_back(mk(K_RD, cyc, mem_addr[d], 64'h0));
      if (core_rsp_valid[d]) obs_q[d].push_back(mk(K_RSP_C, cyc, 16'h0, core_rsp_rdata[d]));
      if (ext_rsp_valid[d])  obs_q[d].push_back(mk(K_RSP_E, cyc, 16'h0, ext_rsp_rdata[d]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [255:0] outs(input int d);
    return {core_req_ready[d], ext_req_ready[d], core_rsp_valid[d], ext_rsp_valid[d],
            mem_write[d], mem_read[d], busy[d], core_rsp_rdata[d], ext_rsp_rdata[d],
            mem_addr[d], mem_wdata[d]};
  endfunction

  // Expected events of one transaction accepted at cycle c0 on an idle DUT.
  task automatic expect_txn(input int d, input bit to_ext, input logic we,
                            input logic [15:0] addr, input logic [63:0] wdata, input int c0);
    int lat;
    lat = (d == 0) ? 1 : 3;
    exp_q.push_back(mk(to_ext ? K_ACC_E : K_ACC_C, c0, 16'h0, 64'h0));
    if (we) begin
      exp_q.push_back(mk(K_WR, c0 + 1, addr, wdata));
      exp_q.push_back(mk(to_ext ? K_RSP_E : K_RSP_C, c0 + 2, 16'h0, held[d][int'(to_ext)]));
    end else begin
      held[d][int'(to_ext)] = model_data(addr);
      exp_q.push_back(mk(K_RD, c0 + 1, addr, 64'h0));
      exp_q.push_back(mk(to_ext ? K_RSP_E : K_RSP_C, c0 + 2 + lat, 16'h0, held[d][int'(to_ext)]));
    end
  endtask

  // Present one request and hold it until accepted (bounded wait).
  task automatic send(input int d, input bit to_ext, input logic we, input logic [15:0] addr,
                      input logic [63:0] wdata, output int c0);
    int n;
    c0 = cyc;
    if (to_ext) begin
      ext_req_valid[d] = 1'b1; ext_req_we[d] = we; ext_req_addr[d] = addr; ext_req_wdata[d] = wdata;
    end else begin
      core_req_valid[d] = 1'b1; core_req_we[d] = we; core_req_addr[d] = addr; core_req_wdata[d] = wdata;
    end
    #1;
    n = 0;
    while (!(to_ext ? ext_req_ready[d] : core_req_ready[d]) && n < 50) begin
      tick();
      #1;
      n++;
    end
    n_assert++;
    if (n >= 50) begin
      n_fail++;
      $display("FAIL ready_timeout: dut %0d waited %0d cycles, required acceptance", d, n);
    end
    tick();
    core_req_valid[d] = 1'b0;
    ext_req_valid[d]  = 1'b0;
  endtask

  task automatic test_reset();
    ev_t e, o;
    tick(); tick();
    core_req_valid[0] = 1'b1; core_req_we[0] = 1'b0; core_req_addr[0] = 16'h0030;
    ext_req_valid[0]  = 1'b1; ext_req_we[0]  = 1'b0; ext_req_addr[0]  = 16'h0031;
    tick();
    #1;
    for (int d = 0; d < 2; d++) begin
      n_assert++;
      if (outs(d) !== 256'h0) begin
        n_fail++;
        $display("FAIL reset_outputs dut %0d: got %h required 0", d, outs(d));
      end
    end
    obs_q[0].delete(); obs_q[1].delete(); exp_q.delete();
    tick();
    reset = 1'b1;
    expect_txn(0, 1'b0, 1'b0, 16'h0030, 64'h0, cyc);
    tick();
    core_req_valid[0] = 1'b0;
    ext_req_valid[0]  = 1'b0;
    repeat (6) tick();
    n_assert++;
    if (obs_q[0].size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL reset_release count: got %0d events required %0d", obs_q[0].size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q[0].size() > 0) begin
      e = exp_q.pop_front(); o = obs_q[0].pop_front(); n_assert++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_release event: got k=%0d c=%0d a=%h d=%h required k=%0d c=%0d a=%h d=%h",
                 o.kind, o.cyc, o.addr, o.data, e.kind, e.cyc, e.addr, e.data);
      end
    end
    exp_q.delete(); obs_q[0].delete();
  endtask

  task automatic test_core_write();
    ev_t e, o;
    int c0;
    send(0, 1'b0, 1'b1, 16'h0010, 64'h0000_0000_DEAD_BEEF, c0);
    expect_txn(0, 1'b0, 1'b1, 16'h0010, 64'h0000_0000_DEAD_BEEF, c0);
    repeat (6) tick();
    n_assert++;
    if (obs_q[0].size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL core_write count: got %0d events required %0d", obs_q[0].size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q[0].size() > 0) begin
      e = exp_q.pop_front(); o = obs_q[0].pop_front(); n_assert++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL core_write event: got k=%0d c=%0d a=%h d=%h required k=%0d c=%0d a=%h d=%h",
                 o.kind, o.cyc, o.addr, o.data, e.kind, e.cyc, e.addr, e.data);
      end
    end
    exp_q.delete(); obs_q[0].delete();
  endtask

  task automatic test_core_read();
    ev_t e, o;
    int c0;
    send(0, 1'b0, 1'b0, 16'h0020, 64'h0, c0);
    expect_txn(0, 1'b0, 1'b0, 16'h0020, 64'h0, c0);
    repeat (8) tick();
    n_assert++;
    if (obs_q[0].size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL core_read count: got %0d events required %0d", obs_q[0].size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q[0].size() > 0) begin
      e = exp_q.pop_front(); o = obs_q[0].pop_front(); n_assert++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL core_read event: got k=%0d c=%0d a=%h d=%h required k=%0d c=%0d a=%h d=%h",
                 o.kind, o.cyc, o.addr, o.data, e.kind, e.cyc, e.addr, e.data);
      end
    end
    exp_q.delete(); obs_q[0].delete();
    n_assert++;
    if (core_rsp_rdata[0] !== 64'h1234) begin
      n_fail++;
      $display("FAIL core_read hold: got %h required %h", core_rsp_rdata[0], 64'h1234);
    end
  endtask

  task automatic test_arbitration();
    ev_t e, o;
    int c0, nc, ne, guard;
    bit cr, er;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin held[d][0] = '0; held[d][1] = '0; end
    tick();
    obs_q[0].delete(); exp_q.delete();
    c0 = cyc;
    for (int k = 0; k < 8; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      expect_txn(0, k[0], 1'b0, (k[0] ? 16'h0200 : 16'h0100) + 16'(k / 2), 64'h0, c0 + 4 * k);
`else
      expect_txn(0, k >= 4, 1'b0, (k >= 4 ? 16'h0200 : 16'h0100) + 16'(k % 4), 64'h0, c0 + 4 * k);
`endif
    end
    nc = 0; ne = 0; guard = 0;
    while ((nc < 4 || ne < 4) && guard < 100) begin
      core_req_valid[0] = (nc < 4); core_req_we[0] = 1'b0; core_req_addr[0] = 16'h0100 + 16'(nc);
      ext_req_valid[0]  = (ne < 4); ext_req_we[0]  = 1'b0; ext_req_addr[0]  = 16'h0200 + 16'(ne);
      #1;
      cr = core_req_valid[0] && core_req_ready[0];
      er = ext_req_valid[0] && ext_req_ready[0];
      tick();
      if (cr) nc++;
      if (er) ne++;
      guard++;
    end
    core_req_valid[0] = 1'b0;
    ext_req_valid[0]  = 1'b0;
    n_assert++;
    if (guard >= 100) begin
      n_fail++;
      $display("FAIL arbitration timeout: core %0d ext %0d grants, required 4 each", nc, ne);
    end
    repeat (6) tick();
    n_assert++;
    if (obs_q[0].size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL arbitration count: got %0d events required %0d", obs_q[0].size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q[0].size() > 0) begin
      e = exp_q.pop_front(); o = obs_q[0].pop_front(); n_assert++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL arbitration event: got k=%0d c=%0d a=%h d=%h required k=%0d c=%0d a=%h d=%h",
                 o.kind, o.cyc, o.addr, o.data, e.kind, e.cyc, e.addr, e.data);
      end
    end
    exp_q.delete(); obs_q[0].delete();
  endtask

  task automatic test_ext_read_lat3();
    ev_t e, o;
    int c0;
    obs_q[1].delete();
    send(1, 1'b1, 1'b0, 16'h0040, 64'h0, c0);
    expect_txn(1, 1'b1, 1'b0, 16'h0040, 64'h0, c0);
    repeat (10) tick();
    n_assert++;
    if (obs_q[1].size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL ext_read_lat3 count: got %0d events required %0d", obs_q[1].size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q[1].size() > 0) begin
      e = exp_q.pop_front(); o = obs_q[1].pop_front(); n_assert++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL ext_read_lat3 event: got k=%0d c=%0d a=%h d=%h required k=%0d c=%0d a=%h d=%h",
                 o.kind, o.cyc, o.addr, o.data, e.kind, e.cyc, e.addr, e.data);
      end
    end
    exp_q.delete(); obs_q[1].delete();
  endtask

  task automatic test_reset_in_wait();
    ev_t e, o;
    int c0, c1;
    send(1, 1'b0, 1'b0, 16'h0050, 64'h0, c0);
    exp_q.push_back(mk(K_ACC_C, c0, 16'h0, 64'h0));
    exp_q.push_back(mk(K_RD, c0 + 1, 16'h0050, 64'h0));
    tick();
    reset = 1'b0;
    #1;
    n_assert++;
    if (outs(1) !== 256'h0) begin
      n_fail++;
      $display("FAIL reset_in_wait outputs: got %h required 0", outs(1));
    end
    repeat (3) tick();
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin held[d][0] = '0; held[d][1] = '0; end
    repeat (4) tick();
    send(1, 1'b0, 1'b1, 16'h0060, 64'h0000_0000_0000_CAFE, c1);
    expect_txn(1, 1'b0, 1'b1, 16'h0060, 64'h0000_0000_0000_CAFE, c1);
    repeat (6) tick();
    n_assert++;
    if (obs_q[1].size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL reset_in_wait count: got %0d events required %0d", obs_q[1].size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q[1].size() > 0) begin
      e = exp_q.pop_front(); o = obs_q[1].pop_front(); n_assert++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_in_wait event: got k=%0d c=%0d a=%h d=%h required k=%0d c=%0d a=%h d=%h",
                 o.kind, o.cyc, o.addr, o.data, e.kind, e.cyc, e.addr, e.data);
      end
    end
    exp_q.delete(); obs_q[1].delete();
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      core_req_valid[d] = 1'b0; core_req_we[d] = 1'b0; core_req_addr[d] = '0; core_req_wdata[d] = '0;
      ext_req_valid[d]  = 1'b0; ext_req_we[d]  = 1'b0; ext_req_addr[d]  = '0; ext_req_wdata[d]  = '0;
      held[d][0] = '0; held[d][1] = '0;
    end
    #1 reset = 1'b0;
    test_reset();
    test_core_write();
    test_core_read();
    test_arbitration();
    test_ext_read_lat3();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
